relu_conv_2d_mac_pipe: RTL and testbench

RELU_CONV_2D_MAC_PIPE -- requirements
Module: relu_conv_2d_mac_pipe

---
 rtl/relu_conv_2d_mac_pipe_pkg.sv | 18 +
 rtl/relu_conv_2d_mac_pipe_sat.sv | 40 ++++
 rtl/relu_conv_2d_mac_pipe.sv | 135 +++++++++++++
 tb/tb_relu_conv_2d_mac_pipe.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/relu_conv_2d_mac_pipe_pkg.sv
// Shared types for the ReLU conv MAC pipeline: the per-sample control tag
// that travels alongside each product through the pipeline.
package relu_conv_2d_mac_pipe_pkg;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } mac_tag_t;

    localparam mac_tag_t TAG_IDLE = mac_tag_t'(3'b000);

    // A tag closes a sum only when it carries a real sample marked last.
    function automatic logic tag_ends_sum(input mac_tag_t tag);
        return tag.valid & tag.last;
    endfunction

endpackage

// File: rtl/relu_conv_2d_mac_pipe_sat.sv
// Combinational post-processing: optional ReLU clamp, then signed saturation
// of the full-width accumulator value down to the output width.
module relu_conv_2d_mac_pipe_sat
    import relu_conv_2d_mac_pipe_pkg::*;
#(
    parameter int ACC_WIDTH  = 64,
    parameter int dout_WIDTH = 48,
    parameter int RELU_EN    = 1
) (
    input  logic signed [ACC_WIDTH-1:0]  acc_value,
    output logic signed [dout_WIDTH-1:0] dout_value,
    output logic                         sat_flag
);

    // Output range limits expressed at accumulator width for direct compare.
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-dout_WIDTH+1){1'b0}}, {(dout_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-dout_WIDTH+1){1'b1}}, {(dout_WIDTH-1){1'b0}}};

    // ReLU takes priority; a clamp to zero is not reported as saturation.
    always_comb begin
        dout_value = acc_value[dout_WIDTH-1:0];
        sat_flag   = 1'b0;
        if ((RELU_EN != 32'sd0) && acc_value[ACC_WIDTH-1]) begin
            dout_value = {dout_WIDTH{1'b0}};
            sat_flag   = 1'b0;
        end else if (acc_value > SAT_MAX) begin
            dout_value = SAT_MAX[dout_WIDTH-1:0];
            sat_flag   = 1'b1;
        end else if (acc_value < SAT_MIN) begin
            dout_value = SAT_MIN[dout_WIDTH-1:0];
            sat_flag   = 1'b1;
        end else begin
            dout_value = acc_value[dout_WIDTH-1:0];
            sat_flag   = 1'b0;
        end
    end

endmodule

// File: rtl/relu_conv_2d_mac_pipe.sv
// Pipelined signed multiply-accumulate with first/last framing, signed
// saturation and optional ReLU on each completed sum.
module relu_conv_2d_mac_pipe
    import relu_conv_2d_mac_pipe_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 32,
    parameter int din1_WIDTH = 32,
    parameter int dout_WIDTH = 48,
    parameter int ACC_WIDTH  = 64,
    parameter int RELU_EN    = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic                         in_valid,
    input  logic                         in_first,
    input  logic                         in_last,
    input  logic signed [din0_WIDTH-1:0] din0,
    input  logic signed [din1_WIDTH-1:0] din1,
    output logic signed [dout_WIDTH-1:0] dout,
    output logic                         out_valid,
    output logic                         dout_sat
);

    localparam int PROD_WIDTH = din0_WIDTH + din1_WIDTH;
    localparam int ID_UNUSED  = ID;

    logic signed [din0_WIDTH-1:0] a_r;
    logic signed [din1_WIDTH-1:0] b_r;
    mac_tag_t                     in_tag_r;

    logic signed [PROD_WIDTH-1:0] a_ext_s;
    logic signed [PROD_WIDTH-1:0] b_ext_s;
    logic signed [PROD_WIDTH-1:0] mult_s;

    logic signed [PROD_WIDTH-1:0] prod_r [NUM_STAGE];
    mac_tag_t                     tag_r  [NUM_STAGE];

    mac_tag_t                     tail_tag_s;
    logic signed [PROD_WIDTH-1:0] tail_prod_s;
    logic signed [ACC_WIDTH-1:0]  tail_ext_s;
    logic signed [ACC_WIDTH-1:0]  acc_r;
    logic signed [ACC_WIDTH-1:0]  acc_next_s;
    logic signed [dout_WIDTH-1:0] sat_dout_s;
    logic                         sat_flag_s;

    // Operand capture; data needs no reset since the tags qualify it.
    always_ff @(posedge clk) begin
        if (ce) begin
            a_r <= din0;
            b_r <= din1;
        end
    end

    // Sign-extend to full product width so the multiply is exact.
    assign a_ext_s = PROD_WIDTH'(a_r);
    assign b_ext_s = PROD_WIDTH'(b_r);
    assign mult_s  = a_ext_s * b_ext_s;

    // Product data pipeline, advancing only on enabled edges.
    always_ff @(posedge clk) begin
        if (ce) begin
            prod_r[0] <= mult_s;
            for (int i = 1; i < NUM_STAGE; i++) begin
                prod_r[i] <= prod_r[i-1];
            end
        end
    end

    // Control tags follow the data; reset drops every in-flight sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_tag_r <= TAG_IDLE;
            for (int i = 0; i < NUM_STAGE; i++) begin
                tag_r[i] <= TAG_IDLE;
            end
        end else if (ce) begin
            in_tag_r.valid <= in_valid;
            in_tag_r.first <= in_valid & in_first;
            in_tag_r.last  <= in_valid & in_last;
            tag_r[0]       <= in_tag_r;
            for (int i = 1; i < NUM_STAGE; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    assign tail_tag_s  = tag_r[NUM_STAGE-1];
    assign tail_prod_s = prod_r[NUM_STAGE-1];
    assign tail_ext_s  = ACC_WIDTH'(tail_prod_s);

    // Next accumulator value: restart on first, otherwise wrap-around add.
    always_comb begin
        acc_next_s = acc_r;
        if (tail_tag_s.valid) begin
            if (tail_tag_s.first) begin
                acc_next_s = tail_ext_s;
            end else begin
                acc_next_s = acc_r + tail_ext_s;
            end
        end else begin
            acc_next_s = acc_r;
        end
    end

    relu_conv_2d_mac_pipe_sat #(
        .ACC_WIDTH  (ACC_WIDTH),
        .dout_WIDTH (dout_WIDTH),
        .RELU_EN    (RELU_EN)
    ) u_sat (
        .acc_value  (acc_next_s),
        .dout_value (sat_dout_s),
        .sat_flag   (sat_flag_s)
    );

    // Accumulator and registered result; everything holds while ce is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r     <= {ACC_WIDTH{1'b0}};
            dout      <= {dout_WIDTH{1'b0}};
            out_valid <= 1'b0;
            dout_sat  <= 1'b0;
        end else if (ce) begin
            acc_r     <= acc_next_s;
            out_valid <= tag_ends_sum(tail_tag_s);
            if (tag_ends_sum(tail_tag_s)) begin
                dout     <= sat_dout_s;
                dout_sat <= sat_flag_s;
            end
        end
    end

endmodule

// File: tb/tb_relu_conv_2d_mac_pipe.sv
// Directed bench: two instances (ReLU on / off) share stimulus; expected
// values are hand-computed constants.
module tb_relu_conv_2d_mac_pipe;

    logic               clk = 1'b0;
    logic               reset;
    logic               ce;
    logic               in_valid;
    logic               in_first;
    logic               in_last;
    logic signed [31:0] din0;
    logic signed [31:0] din1;
    logic signed [47:0] dout0;
    logic signed [47:0] dout1;
    logic               ov0;
    logic               ov1;
    logic               sat0;
    logic               sat1;

    int n_cmp = 0;
    int n_err = 0;

    localparam longint SMAX   = 64'sd140737488355327;
    localparam longint SMIN   = -64'sd140737488355328;
    localparam int     PMAX   = 32'sh7FFF_FFFF;
    localparam int     PMIN   = 32'sh8000_0000;

    always #5 clk = ~clk;

    relu_conv_2d_mac_pipe #(.RELU_EN(1)) dut_relu (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
        .in_first(in_first), .in_last(in_last), .din0(din0), .din1(din1),
        .dout(dout0), .out_valid(ov0), .dout_sat(sat0)
    );

    relu_conv_2d_mac_pipe #(.RELU_EN(0)) dut_lin (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
        .in_first(in_first), .in_last(in_last), .din0(din0), .din1(din1),
        .dout(dout1), .out_valid(ov1), .dout_sat(sat1)
    );

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic drive(input logic c, input logic v, input logic f,
                         input logic l, input int a, input int b);
        ce       = c;
        in_valid = v;
        in_first = f;
        in_last  = l;
        din0     = a;
        din1     = b;
        @(posedge clk);
        #1;
    endtask

    // Called right after the last sample's edge: 3 quiet edges, then result.
    task automatic expect_result(input string tag, input longint e0, input logic s0,
                                 input longint e1, input logic s1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
            check_val({tag, "_early_ov"}, longint'(ov0), 64'sd0);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        check_val({tag, "_ov_relu"}, longint'(ov0), 64'sd1);
        check_val({tag, "_ov_lin"}, longint'(ov1), 64'sd1);
        check_val({tag, "_dout_relu"}, longint'(dout0), e0);
        check_val({tag, "_sat_relu"}, longint'(sat0), longint'(s0));
        check_val({tag, "_dout_lin"}, longint'(dout1), e1);
        check_val({tag, "_sat_lin"}, longint'(sat1), longint'(s1));
    endtask

    initial begin
        reset = 1'b1;
        ce = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        din0 = 32'sd0; din1 = 32'sd0;
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        check_val("rst_ov", longint'(ov0), 64'sd0);
        check_val("rst_dout", longint'(dout0), 64'sd0);
        check_val("rst_sat", longint'(sat0), 64'sd0);
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

        // 3*4 - 2*5 + 7*1 = 9
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3, 4);
        drive(1'b1, 1'b1, 1'b0, 1'b0, -2, 5);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 7, 1);
        expect_result("sum9", 64'sd9, 1'b0, 64'sd9, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        check_val("pulse_ov", longint'(ov0), 64'sd0);
        check_val("hold_dout", longint'(dout0), 64'sd9);

        // No first: continue from acc=9, 9 + 1*2 = 11
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1, 2);
        expect_result("cont", 64'sd11, 1'b0, 64'sd11, 1'b0);

        // Single negative product: ReLU -> 0, linear -> -42
        drive(1'b1, 1'b1, 1'b1, 1'b1, -6, 7);
        expect_result("relu", 64'sd0, 1'b0, -64'sd42, 1'b0);

        // 2*(2^31-1)^2 = 2^63-2^33+2 exceeds 2^47-1
        drive(1'b1, 1'b1, 1'b1, 1'b0, PMAX, PMAX);
        drive(1'b1, 1'b1, 1'b0, 1'b1, PMAX, PMAX);
        expect_result("satpos", SMAX, 1'b1, SMAX, 1'b1);

        // 4*(2^31-1)^2 wraps modulo 2^64 to -2^34+4
        drive(1'b1, 1'b1, 1'b1, 1'b0, PMAX, PMAX);
        drive(1'b1, 1'b1, 1'b0, 1'b0, PMAX, PMAX);
        drive(1'b1, 1'b1, 1'b0, 1'b0, PMAX, PMAX);
        drive(1'b1, 1'b1, 1'b0, 1'b1, PMAX, PMAX);
        expect_result("wrap", 64'sd0, 1'b0, -64'sd17179869180, 1'b0);

        // -2^31*(2^31-1) below -2^47: linear saturates, ReLU clamps
        drive(1'b1, 1'b1, 1'b1, 1'b1, PMIN, PMAX);
        expect_result("satneg", 64'sd0, 1'b0, SMIN, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

        // ce toggling; samples offered while ce=0 must be ignored
        for (int k = 0; k < 16; k++) begin
            int e;
            e = k / 2;
            if (k % 2 == 1)      drive(1'b0, 1'b1, 1'b1, 1'b1, 9, 9);
            else if (k == 0)     drive(1'b1, 1'b1, 1'b1, 1'b0, 1, 1);
            else if (k == 2)     drive(1'b1, 1'b1, 1'b0, 1'b1, 1, 1);
            else if (k == 4)     drive(1'b1, 1'b1, 1'b1, 1'b1, 2, 2);
            else                 drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
            check_val("cetog_ov", longint'(ov0), (e == 5 || e == 6) ? 64'sd1 : 64'sd0);
            if (e >= 5) begin
                check_val("cetog_dout", longint'(dout0), (e == 5) ? 64'sd2 : 64'sd4);
            end
        end

        // Abort a complete one-sample sum in flight with reset (ce low)
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8, 8);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        check_val("midrst_dout", longint'(dout0), 64'sd0);
        check_val("midrst_ov", longint'(ov0), 64'sd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
            check_val("aborted_ov", longint'(ov0), 64'sd0);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 5, 5);
        expect_result("post_rst", 64'sd25, 1'b0, 64'sd25, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
